// File: rtl/step_generator_if.sv
//------------------------------------------------------------------------------
// Module  : step_generator_if
// Purpose : Move-command handshake bundle between a motion planner (master)
//           and the step generator (slave).
// Signals : cmd_valid  - master offers a move command
//           cmd_ready  - slave can accept a command this cycle
//           cmd_dir    - move direction, 1 = forward
//           cmd_steps  - number of steps, unsigned
//           cmd_period - clk cycles between step rising edges, unsigned
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface step_generator_if #(
  parameter int STEP_BITS   = 32,
  parameter int PERIOD_BITS = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_dir;
  logic [STEP_BITS-1:0]   cmd_steps;
  logic [PERIOD_BITS-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/step_generator.sv
//------------------------------------------------------------------------------
// Module  : step_generator
// Purpose : Stepper-motor pulse generator. Accepts a move command (direction,
//           step count, step period), asserts dir, waits a direction setup
//           time, then emits step pulses of fixed high time at the requested
//           period while tracking a signed position count.
// Ports   : clk, resetn  - clock, asynchronous active-low reset
//           cmd          - command handshake (slave side of step_generator_if)
//           abort        - stop the current move (pulse in flight completes)
//           step, dir    - registered motor-driver outputs
//           busy         - move in progress
//           done         - one-cycle pulse at the end of every accepted move
//           position     - signed count of issued steps (wraps)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module step_generator #(
  parameter int STEP_BITS   = 32,
  parameter int PERIOD_BITS = 16,
  parameter int PULSE_WIDTH = 4,
  parameter int DIR_SETUP   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  step_generator_if.slave      cmd,
  input  logic                 abort,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_BITS-1:0] position
);

  // One extra bit so 2*PULSE_WIDTH and any cmd_period fit the cycle counter.
  localparam int CW = PERIOD_BITS + 1;

  localparam logic [CW-1:0] c_min_period  = CW'(2 * PULSE_WIDTH);
  localparam logic [CW-1:0] c_pulse_width = CW'(PULSE_WIDTH);
  localparam logic [CW-1:0] c_pulse_last  = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] c_setup_last  = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] c_cnt_one     = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t               r_state,      w_state;
  logic [CW-1:0]        r_cnt,        w_cnt;
  logic [STEP_BITS-1:0] r_left,       w_left;
  logic [CW-1:0]        r_period,     w_period;
  logic                 r_abort_pend, w_abort_pend;
  logic                 r_step,       w_step;
  logic                 r_dir,        w_dir;
  logic                 r_done,       w_done;
  logic [STEP_BITS-1:0] r_position,   w_position;

  logic [CW-1:0]        w_cmd_period;
  logic [CW-1:0]        w_eff_period;
  logic [STEP_BITS-1:0] w_pos_stepped;

  always_comb begin
    w_cmd_period  = {1'b0, cmd.cmd_period};
    w_eff_period  = (w_cmd_period < c_min_period) ? c_min_period : w_cmd_period;
    w_pos_stepped = r_dir ? (r_position + STEP_BITS'(1))
                          : (r_position - STEP_BITS'(1));

    w_state      = r_state;
    w_cnt        = r_cnt;
    w_left       = r_left;
    w_period     = r_period;
    w_abort_pend = r_abort_pend;
    w_step       = r_step;
    w_dir        = r_dir;
    w_done       = 1'b0;
    w_position   = r_position;

    case (r_state)
      IDLE: begin
        w_abort_pend = 1'b0;
        w_step       = 1'b0;
        if (cmd.cmd_valid) begin
          if (cmd.cmd_steps == '0) begin
            // Empty move: acknowledge with done, leave dir alone.
            w_done = 1'b1;
          end else begin
            w_state  = SETUP;
            w_dir    = cmd.cmd_dir;
            w_left   = cmd.cmd_steps;
            w_period = w_eff_period;
            w_cnt    = c_setup_last;
          end
        end
      end

      SETUP: begin
        if (abort) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end else if (r_cnt == '0) begin
          w_state    = HIGH;
          w_step     = 1'b1;
          w_cnt      = c_pulse_last;
          w_left     = r_left - STEP_BITS'(1);
          w_position = w_pos_stepped;
        end else begin
          w_cnt = r_cnt - c_cnt_one;
        end
      end

      HIGH: begin
        // Abort is remembered so the pulse is never truncated.
        if (abort) begin
          w_abort_pend = 1'b1;
        end
        if (r_cnt == '0) begin
          w_step = 1'b0;
          if (abort || r_abort_pend) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end else begin
            w_state = LOW;
            w_cnt   = r_period - c_pulse_width - c_cnt_one;
          end
        end else begin
          w_cnt = r_cnt - c_cnt_one;
        end
      end

      LOW: begin
        if (abort) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end else if (r_cnt == '0) begin
          if (r_left == '0) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end else begin
            w_state    = HIGH;
            w_step     = 1'b1;
            w_cnt      = c_pulse_last;
            w_left     = r_left - STEP_BITS'(1);
            w_position = w_pos_stepped;
          end
        end else begin
          w_cnt = r_cnt - c_cnt_one;
        end
      end

      default: begin
        w_state = IDLE;
        w_step  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_left       <= '0;
      r_period     <= '0;
      r_abort_pend <= 1'b0;
      r_step       <= 1'b0;
      r_dir        <= 1'b0;
      r_done       <= 1'b0;
      r_position   <= '0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_left       <= w_left;
      r_period     <= w_period;
      r_abort_pend <= w_abort_pend;
      r_step       <= w_step;
      r_dir        <= w_dir;
      r_done       <= w_done;
      r_position   <= w_position;
    end
  end

  assign cmd.cmd_ready = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign step          = r_step;
  assign dir           = r_dir;
  assign done          = r_done;
  assign position      = r_position;

endmodule

`default_nettype wire

// File: tb/tb_step_generator.sv
//------------------------------------------------------------------------------
// Module  : tb_step_generator
// Purpose : Self-checking bench for step_generator (DIR_SETUP=2,
//           PULSE_WIDTH=2, 8-bit position). A per-cycle expected waveform is
//           computed from each move's timing rules and compared every cycle;
//           literal checks pin key points of each scenario.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_step_generator;

  localparam int SB   = 8;
  localparam int PB   = 8;
  localparam int PW   = 2;
  localparam int DS   = 2;
  localparam int MAXC = 1024;

  logic          clk;
  logic          resetn;
  logic          abort;
  logic          step;
  logic          dir;
  logic          busy;
  logic          done;
  logic [SB-1:0] position;

  step_generator_if #(.STEP_BITS(SB), .PERIOD_BITS(PB)) cmd_bus ();

  step_generator #(
    .STEP_BITS  (SB),
    .PERIOD_BITS(PB),
    .PULSE_WIDTH(PW),
    .DIR_SETUP  (DS)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .cmd     (cmd_bus),
    .abort   (abort),
    .step    (step),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .position(position)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges so far; exp_*[c] = value after edge c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          exp_step [0:MAXC-1];
  logic          exp_dir  [0:MAXC-1];
  logic          exp_busy [0:MAXC-1];
  logic          exp_done [0:MAXC-1];
  logic [SB-1:0] exp_pos  [0:MAXC-1];

  int n_pass  = 0;
  int n_total = 0;
  int mv_end  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  // Model: fill the expected waveform of one move accepted at edge e0.
  // ab = edge at which abort is sampled (0 = none).
  task automatic plan(input int e0, input logic d, input int n, input int per, input int ab);
    int p, endc, ns;
    logic [SB-1:0] base;
    logic d0;
    p    = (per < 2 * PW) ? 2 * PW : per;
    base = exp_pos[e0-1];
    d0   = exp_dir[e0-1];
    if (n == 0) begin
      endc = e0;
      ns   = 0;
    end else begin
      endc = e0 + DS + n * p;
      ns   = n;
      if (ab > 0 && ab < endc) begin
        int t;
        t = ab - (e0 + DS);
        if (t <= 0) begin
          endc = ab;
          ns   = 0;
        end else begin
          int k, ph;
          k    = (t - 1) / p;
          ph   = t - k * p;
          ns   = k + 1;
          endc = (ph <= PW) ? (e0 + DS + k * p + PW) : ab;
        end
      end
    end
    for (int c = e0; c < MAXC; c++) begin
      int cnt;
      logic s;
      cnt = 0;
      s   = 1'b0;
      for (int k = 0; k < ns; k++) begin
        if (c >= e0 + DS + k * p) cnt++;
        if (c >= e0 + DS + k * p && c < e0 + DS + k * p + PW && c < endc) s = 1'b1;
      end
      exp_step[c] = s;
      exp_busy[c] = (c < endc);
      exp_done[c] = (c == endc);
      exp_dir[c]  = (n == 0) ? d0 : d;
      exp_pos[c]  = d ? (base + SB'(cnt)) : (base - SB'(cnt));
    end
    mv_end = endc;
  endtask

  task automatic model_reset_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      exp_step[c] = 1'b0;
      exp_dir[c]  = 1'b0;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
      exp_pos[c]  = '0;
    end
    mv_end = c0;
  endtask

  // Called at a negedge; e0 is the next rising edge.
  task automatic issue(input logic d, input int n, input int per, input int ab_rel,
                       input logic ab_e0, output int e0);
    e0 = cyc + 1;
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_dir    = d;
    cmd_bus.cmd_steps  = SB'(n);
    cmd_bus.cmd_period = PB'(per);
    abort              = ab_e0;
    plan(e0, d, n, per, (ab_rel > 0) ? e0 + ab_rel : 0);
    @(negedge clk);
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_steps  = SB'($urandom_range(1, 200));
    cmd_bus.cmd_period = PB'($urandom_range(0, 255));
    abort              = 1'b0;
    if (ab_rel > 0) begin
      while (cyc < e0 + ab_rel - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 400 && cyc < c; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && cyc < mv_end; i++) @(negedge clk);
    chk("wait_idle_reached", (cyc >= mv_end), 1);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("step",      step,              exp_step[cyc]);
      chk("dir",       dir,               exp_dir[cyc]);
      chk("busy",      busy,              exp_busy[cyc]);
      chk("done",      done,              exp_done[cyc]);
      chk("position",  position,          exp_pos[cyc]);
      chk("cmd_ready", cmd_bus.cmd_ready, !exp_busy[cyc]);
    end
  end

  initial begin
    #30000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    for (int c = 0; c < MAXC; c++) begin
      exp_step[c] = 1'b0;
      exp_dir[c]  = 1'b0;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
      exp_pos[c]  = '0;
    end
    resetn             = 1'b1;
    abort              = 1'b0;
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_dir    = 1'b0;
    cmd_bus.cmd_steps  = '0;
    cmd_bus.cmd_period = '0;
    #2 resetn = 1'b0;

    wait_cyc(3);
    chk("reset_step",  step,              0);
    chk("reset_busy",  busy,              0);
    chk("reset_pos",   position,          0);
    chk("reset_ready", cmd_bus.cmd_ready, 1);
    chk_en = 1'b1;
    resetn = 1'b1;
    @(negedge clk);

    // Basic 3-step forward move; garbage commands while busy are ignored.
    issue(1'b1, 3, 5, 0, 1'b0, e0);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_dir   = 1'b0;
    cmd_bus.cmd_steps = SB'(9);
    @(negedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    wait_cyc(e0 + 2);  chk("A_rise1", step, 1);
    wait_cyc(e0 + 4);  chk("A_fall1", step, 0);
    wait_cyc(e0 + 7);  chk("A_rise2", step, 1);
    wait_cyc(e0 + 17); chk("A_done", done, 1);
    chk("A_pos", position, 3);
    wait_idle();

    // Zero-step command.
    issue(1'b0, 0, 9, 0, 1'b0, e0);
    wait_cyc(e0);
    chk("Z_done",  done,              1);
    chk("Z_dir",   dir,               1);
    chk("Z_ready", cmd_bus.cmd_ready, 1);
    wait_idle();
    @(negedge clk);

    // Period below minimum, abort held in IDLE alongside the command.
    issue(1'b1, 3, 1, 0, 1'b1, e0);
    wait_cyc(e0 + 2);  chk("P_rise1", step, 1);
    wait_cyc(e0 + 4);  chk("P_low",   step, 0);
    wait_cyc(e0 + 6);  chk("P_rise2", step, 1);
    wait_cyc(e0 + 14); chk("P_done", done, 1);
    chk("P_pos", position, 6);
    wait_idle();
    @(negedge clk);

    // Abort during HIGH of step 2 of 5.
    issue(1'b0, 5, 5, 8, 1'b0, e0);
    wait_cyc(e0 + 8);  chk("H_still_high", step, 1);
    wait_cyc(e0 + 9);  chk("H_fall", step, 0);
    chk("H_done", done, 1);
    chk("H_pos", position, 4);
    wait_cyc(e0 + 12); chk("H_no_step3", step, 0);
    wait_idle();

    // Abort in SETUP.
    issue(1'b1, 2, 6, 1, 1'b0, e0);
    wait_cyc(e0 + 1);
    chk("S_done", done,     1);
    chk("S_pos",  position, 4);
    wait_idle();
    @(negedge clk);

    // Abort in LOW.
    issue(1'b1, 3, 6, 6, 1'b0, e0);
    wait_cyc(e0 + 6);
    chk("L_done", done,     1);
    chk("L_pos",  position, 5);
    wait_idle();
    @(negedge clk);

    // Reset asserted mid-LOW.
    issue(1'b1, 4, 8, 0, 1'b0, e0);
    wait_cyc(e0 + 5);
    chk("R_pre_pos", position, 6);
    @(posedge clk);
    #1;
    model_reset_from(cyc);
    resetn = 1'b0;
    #1;
    chk("R_step", step,     0);
    chk("R_busy", busy,     0);
    chk("R_pos",  position, 0);
    chk("R_done", done,     0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Command on the first edge after reset: two reverse steps from zero.
    issue(1'b0, 2, 5, 0, 1'b0, e0);
    wait_cyc(e0 + 12);
    chk("N_done", done,     1);
    chk("N_pos",  position, 8'hFE);
    wait_idle();
    @(negedge clk);

    // Forward move: dir changes exactly at acceptance.
    chk("D_dir_before", dir, 0);
    issue(1'b1, 1, 4, 0, 1'b0, e0);
    wait_cyc(e0);
    chk("D_dir_after", dir, 1);
    wait_cyc(e0 + 6);
    chk("D_done", done,     1);
    chk("D_pos",  position, 8'hFF);
    wait_idle();
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_generator.md
STEP_GENERATOR -- requirements
Module: step_generator

Interface
REQ-001 SHALL have parameter STEP_BITS, default 32, width of step count and position.
REQ-002 SHALL have parameter PERIOD_BITS, default 16, width of step period in clk cycles.
REQ-003 SHALL have parameter PULSE_WIDTH, default 4, step high time in clk cycles (>=1).
REQ-004 SHALL have parameter DIR_SETUP, default 2, cycles from dir update to first step rise (>=1).
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  input  1  system clock; resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have cmd_valid  input  1  move command offered.
REQ-007 SHALL have cmd_ready  output  1  generator accepts a command.
REQ-008 SHALL have cmd_dir  input  1  move direction (1 = forward).
REQ-009 SHALL have cmd_steps  input  STEP_BITS  number of steps, unsigned.
REQ-010 SHALL have cmd_period  input  PERIOD_BITS  cycles between step rising edges, unsigned.
REQ-011 SHALL have abort  input  1  stop current move.
REQ-012 SHALL have step  output  1  step pulse to the motor driver.
REQ-013 SHALL have dir  output  1  direction to the motor driver.
REQ-014 SHALL have busy  output  1  move in progress.
REQ-015 SHALL have done  output  1  one-cycle pulse at move end.
REQ-016 SHALL have position  output  STEP_BITS  signed count of issued steps.

Function
REQ-017 SHALL implement states IDLE, SETUP, HIGH, LOW; cmd_ready = (state == IDLE); busy = (state != IDLE).
REQ-018 SHALL accept a command on a clk edge with cmd_valid && cmd_ready (acceptance edge E0), latching cmd_steps and effective period.
REQ-019 SHALL use effective period = max(cmd_period, 2*PULSE_WIDTH), computed at acceptance.
REQ-020 SHALL, for cmd_steps == 0, stay in IDLE, leave dir unchanged, and assert done for the cycle after E0.
REQ-021 SHALL, for cmd_steps > 0, update dir to cmd_dir at E0 and enter SETUP for DIR_SETUP cycles.
REQ-022 SHALL raise step first at edge E0+DIR_SETUP and raise subsequent steps exactly one effective period apart.
REQ-023 SHALL hold step high exactly PULSE_WIDTH cycles (HIGH), then low for period-PULSE_WIDTH cycles (LOW).
REQ-024 SHALL update position on each step rising edge: +1 if dir=1, -1 if dir=0, two's-complement wrap at limits.
REQ-025 SHALL, after LOW of the last step, return to IDLE and assert done for one cycle; done edge = E0+DIR_SETUP+cmd_steps*period.
REQ-026 SHALL hold dir constant while busy; cmd_* inputs SHALL be ignored while busy.
REQ-027 SHALL, on abort in SETUP or LOW, go to IDLE next edge with done pulsed; no further step issued.
REQ-028 SHALL, on abort in HIGH, finish the current high time, then go to IDLE with done pulsed (no truncated pulse).
REQ-029 SHALL ignore abort in IDLE; abort together with cmd_valid in IDLE SHALL accept the command.
REQ-030 SHALL register step, dir, done (glitch-free, no combinational path from inputs).
REQ-031 SHALL use an internal step counter of STEP_BITS and a cycle counter of PERIOD_BITS+1 bits.

Reset
REQ-032 SHALL on resetn low, asynchronously: state=IDLE, step=0, dir=0, done=0, busy=0, position=0, counters=0.
REQ-033 SHALL, on reset mid-move, drop step immediately and discard the move; no done pulse.
REQ-034 SHALL accept a command on the first clk edge after resetn deasserts.

Verification
REQ-035 SHALL check (DIR_SETUP=2, PULSE_WIDTH=2) cmd_steps=3, period=5, dir=1 at E0 -> step rises E0+2,+7,+12, each 2 cycles high; done at E0+17; position=3.
REQ-036 SHALL check cmd_steps=0 -> no step, dir unchanged, done one cycle after E0, cmd_ready stays 1.
REQ-037 SHALL check period=1 with PULSE_WIDTH=2 -> rises spaced 4 cycles, high 2.
REQ-038 SHALL check abort during HIGH of step 2 of 5 -> pulse completes full 2 cycles, done pulses, position=±2, no step 3.
REQ-039 SHALL check dir=0 from position 0, 2 steps -> position = all-ones-minus-one (-2); then dir=1 move, dir changes at E0 only.
REQ-040 SHALL check resetn low mid-LOW -> step=0, busy=0, position=0 asynchronously; no done.
